// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface prog_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a checksummed byte frame into instruction memory,
// then releases the processor only from a verified image.
module prog_loader #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_loader_if.slave         rx,
    input  logic                 reload,
    output logic                 imem_wr_en,
    output logic [ADDR_W-1:0]    imem_wr_addr,
    output logic [INSTR_W-1:0]   imem_wr_data,
    output logic                 controller_enable,
    output logic                 proc_restart,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      word_count
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [8:0]      DEPTH9 = 9'(1 << ADDR_W);
    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] WC_ONE = (ADDR_W + 1)'(1);

    logic [2:0]        state;
    logic [ADDR_W:0]   count;
    logic [7:0]        csum;
    logic [7:0]        hi;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic [ADDR_W:0]   wc_inc;
    logic [7:0]        byte_in;

    assign byte_in  = rx.rx_data;
    assign accept   = rx.rx_valid && rx.rx_ready;
    assign wc_inc   = word_count + WC_ONE;

    assign rx.rx_ready = (state == S_IDLE) || (state == S_HI) ||
                         (state == S_LO)   || (state == S_CHK);

    assign controller_enable = (state == S_RUN);
    assign load_done         = (state == S_RUN);
    assign load_error        = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            csum         <= '0;
            hi           <= '0;
            ptr          <= '0;
            word_count   <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            proc_restart <= 1'b0;
        end else begin
            imem_wr_en   <= 1'b0;
            proc_restart <= 1'b0;
            // Abort wins over any byte arriving in the same cycle.
            if (reload && state != S_IDLE) begin
                state      <= S_IDLE;
                word_count <= '0;
                csum       <= '0;
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        if ({1'b0, byte_in} > DEPTH9) begin
                            state <= S_ERR;
                        end else begin
                            count      <= (byte_in == 8'd0) ? DEPTH
                                                            : byte_in[ADDR_W:0];
                            csum       <= byte_in;
                            ptr        <= '0;
                            word_count <= '0;
                            state      <= S_HI;
                        end
                    end
                    S_HI: begin
                        hi    <= byte_in;
                        csum  <= csum ^ byte_in;
                        state <= S_LO;
                    end
                    S_LO: begin
                        csum         <= csum ^ byte_in;
                        imem_wr_en   <= 1'b1;
                        imem_wr_addr <= ptr;
                        imem_wr_data <= INSTR_W'({hi, byte_in});
                        ptr          <= ptr + 1'b1;
                        word_count   <= wc_inc;
                        state        <= (wc_inc == count) ? S_CHK : S_HI;
                    end
                    S_CHK: begin
                        if (byte_in == csum) begin
                            state        <= S_RUN;
                            proc_restart <= 1'b1;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus time.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic        imem_wr_en;
    logic [5:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        controller_enable;
    logic        proc_restart;
    logic        load_done;
    logic        load_error;
    logic [6:0]  word_count;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;
    int restart_cnt = 0;
    logic [21:0] sb[$];
    logic [15:0] img[64];

    prog_loader_if rx_if();

    prog_loader dut (
        .clk(clk),
        .rst(rst),
        .rx(rx_if),
        .reload(reload),
        .imem_wr_en(imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .controller_enable(controller_enable),
        .proc_restart(proc_restart),
        .load_done(load_done),
        .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        logic [21:0] exp;
        if (proc_restart) restart_cnt++;
        if (imem_wr_en) begin
            wr_pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, none expected",
                         imem_wr_addr, imem_wr_data);
            end else begin
                exp = sb.pop_front();
                if ({imem_wr_addr, imem_wr_data} !== exp) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_wr_addr, imem_wr_data, exp[21:16], exp[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_if.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        n = 0;
        while (!rx_if.rx_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rx_ready stayed 0, byte %h", b);
        end else begin
            @(posedge clk); #1;
        end
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int n,
                              input bit bad, input bit gap);
        logic [7:0] cs;
        cs = hdr;
        send_byte(hdr, gap);
        for (int i = 0; i < n; i++) begin
            cs = cs ^ img[i][15:8] ^ img[i][7:0];
            send_byte(img[i][15:8], gap);
            sb.push_back({6'(i), img[i]});
            send_byte(img[i][7:0], gap);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reload = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({imem_wr_en, imem_wr_addr, imem_wr_data, controller_enable,
             proc_restart, load_done, load_error, word_count, rx_if.rx_ready}
            !== {1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: en=%b addr=%0d data=%h ce=%b pr=%b done=%b err=%b wc=%0d rdy=%b",
                     imem_wr_en, imem_wr_addr, imem_wr_data, controller_enable,
                     proc_restart, load_done, load_error, word_count, rx_if.rx_ready);
        end
    endtask

    task automatic test_good2();
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        send_frame(8'h02, 2, 1'b0, 1'b0);
        checks++;
        if ({proc_restart, controller_enable, load_done, rx_if.rx_ready, load_error}
            !== 5'b11100) begin
            errors++;
            $display("FAIL good2_run: pr/ce/done/rdy/err=%b want 11100",
                     {proc_restart, controller_enable, load_done, rx_if.rx_ready, load_error});
        end
        checks++;
        if (word_count !== 7'd2) begin
            errors++;
            $display("FAIL good2_wc: got %0d want 2", word_count);
        end
        @(posedge clk); #1;
        checks++;
        if ({proc_restart, controller_enable, load_done} !== 3'b011) begin
            errors++;
            $display("FAIL good2_restart_pulse: pr/ce/done=%b want 011",
                     {proc_restart, controller_enable, load_done});
        end
    endtask

    task automatic test_bad_checksum();
        int r0;
        pulse_reload();
        checks++;
        if ({word_count, load_done, controller_enable, rx_if.rx_ready} !== {7'd0, 3'b001}) begin
            errors++;
            $display("FAIL reload_from_run: wc=%0d done=%b ce=%b rdy=%b",
                     word_count, load_done, controller_enable, rx_if.rx_ready);
        end
        r0 = restart_cnt;
        send_frame(8'h02, 2, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({load_error, controller_enable, rx_if.rx_ready, load_done} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_csum_err: err/ce/rdy/done=%b want 1000",
                     {load_error, controller_enable, rx_if.rx_ready, load_done});
        end
        checks++;
        if (restart_cnt !== r0) begin
            errors++;
            $display("FAIL bad_csum_restart: got %0d pulses want 0", restart_cnt - r0);
        end
    endtask

    task automatic test_full_image();
        pulse_reload();
        for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
        send_frame(8'h00, 64, 1'b0, 1'b0);
        checks++;
        if ({word_count, load_done, proc_restart} !== {7'd64, 2'b11}) begin
            errors++;
            $display("FAIL full_image: wc=%0d done=%b pr=%b want 64 1 1",
                     word_count, load_done, proc_restart);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_image_pending: %0d writes missing", sb.size());
        end
    endtask

    task automatic test_illegal_header();
        int w0;
        pulse_reload();
        w0 = wr_pulses;
        send_byte(8'h41, 1'b0);
        checks++;
        if ({load_error, rx_if.rx_ready, controller_enable} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_hdr: err/rdy/ce=%b want 100",
                     {load_error, rx_if.rx_ready, controller_enable});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_pulses !== w0 || load_error !== 1'b1) begin
            errors++;
            $display("FAIL illegal_hdr_hold: writes=%0d err=%b want 0 1",
                     wr_pulses - w0, load_error);
        end
    endtask

    task automatic test_flow_control();
        int w0;
        pulse_reload();
        w0 = wr_pulses;
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        send_frame(8'h02, 2, 1'b0, 1'b1);
        checks++;
        if ({proc_restart, controller_enable, load_done, rx_if.rx_ready} !== 4'b1110) begin
            errors++;
            $display("FAIL flow_run: pr/ce/done/rdy=%b want 1110",
                     {proc_restart, controller_enable, load_done, rx_if.rx_ready});
        end
        checks++;
        if (wr_pulses - w0 !== 2 || word_count !== 7'd2) begin
            errors++;
            $display("FAIL flow_writes: pulses=%0d wc=%0d want 2 2",
                     wr_pulses - w0, word_count);
        end
    endtask

    task automatic test_reload_midload();
        pulse_reload();
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        sb.push_back({6'd0, 16'h1122});
        send_byte(8'h22, 1'b0);
        pulse_reload();
        checks++;
        if ({word_count, rx_if.rx_ready, load_done, load_error} !== {7'd0, 3'b100}) begin
            errors++;
            $display("FAIL reload_mid: wc=%0d rdy=%b done=%b err=%b",
                     word_count, rx_if.rx_ready, load_done, load_error);
        end
        img[0] = 16'h5A5A;
        img[1] = 16'h0F0F;
        img[2] = 16'hC3C3;
        send_frame(8'h03, 3, 1'b0, 1'b0);
        checks++;
        if ({word_count, load_done, proc_restart} !== {7'd3, 2'b11}) begin
            errors++;
            $display("FAIL reload_newframe: wc=%0d done=%b pr=%b want 3 1 1",
                     word_count, load_done, proc_restart);
        end
    endtask

    task automatic test_rst_in_run();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({controller_enable, load_done, proc_restart, word_count, rx_if.rx_ready}
            !== {3'b000, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_in_run: ce=%b done=%b pr=%b wc=%0d rdy=%b",
                     controller_enable, load_done, proc_restart, word_count, rx_if.rx_ready);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d writes never seen", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_good2();
        test_bad_checksum();
        test_full_image();
        test_illegal_header();
        test_flow_control();
        test_reload_midload();
        test_rst_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
